// File: rtl/mem_responder.sv
// Byte-wide memory responder: RAM plus a memory-mapped UART port.
// TX path is a small FIFO; RX path is a single holding register.
module mem_responder #(
    parameter int RAM_ADDR_W    = 17,
    parameter int TX_DEPTH_LOG2 = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int RAM_SIZE = 2 ** RAM_ADDR_W;
    localparam int DEPTH    = 2 ** TX_DEPTH_LOG2;
    localparam logic [TX_DEPTH_LOG2:0] FULL_CNT = DEPTH[TX_DEPTH_LOG2:0];
    localparam logic [17:0] IO_DATA = 18'h30000;
    localparam logic [17:0] IO_STAT = 18'h30004;

    logic [7:0] ram [RAM_SIZE];
    logic [7:0] fifo [DEPTH];

    logic [TX_DEPTH_LOG2-1:0] head;
    logic [TX_DEPTH_LOG2-1:0] tail;
    logic [TX_DEPTH_LOG2:0]   count;

    logic       overflow;
    logic       rx_avail;
    logic [7:0] rx_hold;

    logic                  is_io;
    logic                  io_data_sel;
    logic                  io_stat_sel;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  drop;
    logic                  pop;
    logic                  rx_take;
    logic                  rx_read;
    logic [7:0]            rd_next;
    logic                  unused_hi;

    assign unused_hi   = ^mem_a[31:18];
    assign is_io       = (mem_a[17:16] == 2'b11);
    assign io_data_sel = is_io && (mem_a[17:0] == IO_DATA);
    assign io_stat_sel = is_io && (mem_a[17:0] == IO_STAT);
    assign ram_idx     = mem_a[RAM_ADDR_W-1:0];

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);

    // Push decision looks only at the pre-edge count, so a pop on the
    // same edge never makes room for a push into a full FIFO.
    assign push    = rdy_in && mem_wr && io_data_sel && !fifo_full;
    assign drop    = rdy_in && mem_wr && io_data_sel && fifo_full;
    assign pop     = !fifo_empty && tx_ready;
    assign rx_take = rx_valid && !rx_avail;
    assign rx_read = rdy_in && !mem_wr && io_data_sel;

    assign tx_valid       = !fifo_empty;
    assign tx_data        = fifo[head];
    assign io_buffer_full = fifo_full;
    assign rx_ready       = !rx_avail;

    // RAM write port; contents survive reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in && mem_wr && !is_io) begin
            ram[ram_idx] <= mem_dout;
        end
    end

    // FIFO storage; entries are only visible while count is non-zero.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo[tail] <= mem_dout;
        end
    end

    // Read data selection from pre-edge state.
    always_comb begin
        rd_next = 8'h00;
        if (!is_io) begin
            rd_next = ram[ram_idx];
        end else if (io_data_sel) begin
            rd_next = rx_avail ? rx_hold : 8'h00;
        end else if (io_stat_sel) begin
            rd_next = {5'b0, overflow, fifo_empty, rx_avail};
        end
    end

    // Registered read port; writes and stalled cycles hold the last value.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_din <= 8'h00;
        end else if (rdy_in && !mem_wr) begin
            mem_din <= rd_next;
        end
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sticky overflow: set on a dropped TX byte, cleared only by reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // RX holding register; a capture wins over a clearing read.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_avail <= 1'b0;
            rx_hold  <= 8'h00;
        end else if (rx_take) begin
            rx_avail <= 1'b1;
            rx_hold  <= rx_data;
        end else if (rx_read) begin
            rx_avail <= 1'b0;
        end
    end

endmodule
